pdm_sample: RTL and testbench
=============================

# pdm_sample

Front end for the voice path that converts the 1-bit PDM microphone stream into PCM words for storage. A clock-enable `count_en`, generated upstream at the microphone bit rate, marks the cycles on which `micData` is valid. The block runs a boxcar ones-count decimator over `DECIM` bits to produce signed 16-bit PCM samples. It packs two samples per 32-bit word and issues a one-cycle write strobe to the sample RAM writer downstream.

## Interface
- `DECIM`, default 64: PDM bits per PCM sample. Must be a power of two, 4..32768.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: reset, asynchronous, active-low. The port is named `rst`, but the block is in reset while `rst == 0`.
- `count_en` input 1: bit-valid strobe. `micData` is consumed on every rising edge where `count_en == 1`.
- `micData` input 1: PDM data bit, already synchronous to `clk` (registered upstream).
- `ram_data` output 32: packed PCM pair `{newer_sample[15:0], older_sample[15:0]}`.
- `ram_wr` output 1: one-cycle write strobe. `ram_data` is valid whenever `ram_wr == 1`.

## Operation
- State:
  - `bit_cnt` (log2(DECIM) bits)
  - `ones_acc` (log2(DECIM)+1 bits)
  - `half` flag
  - `low_hold` (16 bits)
  - `ram_data` and `ram_wr` registers
- Enabled cycle (`count_en == 1`):
  - `bit_cnt` increments and wraps at `DECIM`.
  - `ones_acc` adds `micData`.
- Window close: on the enabled cycle where `bit_cnt == DECIM-1`:
  - Compute `ones = ones_acc + micData`, in the range 0..DECIM.
  - Compute `pcm = ones - DECIM/2`, signed, sign-extended to 16 bits. Range is -DECIM/2..+DECIM/2.
  - `ones_acc` is cleared to 0. The closing bit is counted in this window, not the next.
- Packing at window close:
  - If `half == 0`: `low_hold <= pcm` and `half <= 1`.
  - If `half == 1`: `ram_data <= {pcm, low_hold}`, `ram_wr <= 1`, `half <= 0`.
- `ram_wr` is 0 on every other cycle and never stays high for two consecutive cycles.
- `ram_data` holds its last written value until the next write.
- `count_en == 0`: all state holds, and `ram_wr` still deasserts.
- A gap in `count_en` does not disturb a window in progress.
- Reset (asynchronous, any time, including mid-window or mid-pair):
  - `bit_cnt`, `ones_acc`, `half`, `low_hold`, `ram_data` and `ram_wr` all go to 0.
  - Partial windows and unpaired samples are discarded.
  - After release, the first word needs 2*DECIM fresh enabled bits.

## Timing
- `micData` is sampled on the rising edge where `count_en == 1`. There is no internal synchronizer.
- Latency: `ram_wr` is high in the cycle immediately after the edge that consumed bit number 2*DECIM of the pair.
- With continuous `count_en` from reset release, words appear every 2*DECIM cycles. The first `ram_wr` is in cycle 2*DECIM, counting the first consuming edge as edge 1.
- Maximum sustained rate: `count_en` high every cycle.
- Downstream must accept one word per 2*DECIM enabled cycles. The block provides no backpressure.

## Structure
- Package `pdm_pkg`:
  - `PCM_W = 16`
  - `typedef logic signed [PCM_W-1:0] pcm_t`
  - default `DECIM_DEF = 64`
  - `typedef logic [31:0] ram_word_t`
- Sub-module `pdm_decim`:
  - Holds `bit_cnt` and `ones_acc`.
  - Outputs `pcm_t pcm` and a one-cycle `pcm_valid` pulse on the cycle after window close.
  - `pdm_sample` does the pair packing and drives the `ram_data`/`ram_wr` registers.
  - Overall latency stays as specified: pack from the combinational window-close result, or compensate.

## Test plan
All scenarios use DECIM = 64.
- **Constant ones:** `micData = 1`, `count_en = 1` for 2000 cycles → 15 writes, each `ram_data = 0x0020_0020`. The first `ram_wr` lands exactly 128 cycles after enable starts; writes are spaced 128 cycles apart.
- **Constant zeros:** `micData = 0` → every word is `0xFFE0_FFE0`.
- **Alternating bits:** `micData` alternates 1/0 → every word is `0x0000_0000`.
- **Sparse enable:** `count_en` high every 4th cycle with `micData = 1` → same words as constant ones. Writes are 512 cycles apart, and `ram_wr` is a single-cycle pulse.
- **Mixed pair:** first window all ones, second all zeros → `0xFFE0_0020`, confirming the older sample sits in `[15:0]`.
- **Reset mid-pair:** assert `rst = 0` after 100 enabled bits, then release → all outputs are 0 during reset. The first post-reset write occurs after 128 new enabled bits, and its value contains no pre-reset data.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared types and constants for the PDM-to-PCM voice front end.
package pdm_pkg;
    localparam int PCM_W     = 16;
    localparam int DECIM_DEF = 64;

    typedef logic signed [PCM_W-1:0] pcm_t;
    typedef logic [31:0]             ram_word_t;
endpackage

// File: rtl/pdm_decim.sv
// Boxcar ones-count decimator: DECIM PDM bits in, one signed PCM sample out.
module pdm_decim
    import pdm_pkg::*;
#(
    parameter int DECIM = DECIM_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic count_en,
    input  logic micData,
    output pcm_t pcm,
    output logic pcm_valid,
    output logic close_now,
    output pcm_t pcm_now
);
    localparam int CW = $clog2(DECIM);

    logic [CW-1:0] r_bit_cnt;
    logic [CW:0]   r_ones_acc;
    logic [CW:0]   w_ones;
    logic          w_close;
    pcm_t          w_pcm;

    // The closing bit belongs to the window it closes.
    assign w_ones  = r_ones_acc + {{CW{1'b0}}, micData};
    assign w_close = count_en && (r_bit_cnt == CW'(DECIM - 1));
    assign w_pcm   = pcm_t'(PCM_W'(w_ones) - PCM_W'(DECIM / 2));

    assign close_now = w_close;
    assign pcm_now   = w_pcm;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bit_cnt  <= '0;
            r_ones_acc <= '0;
            pcm        <= '0;
            pcm_valid  <= 1'b0;
        end else begin
            pcm_valid <= 1'b0;
            if (count_en) begin
                r_bit_cnt <= r_bit_cnt + CW'(1);
                if (w_close) begin
                    r_ones_acc <= '0;
                    pcm        <= w_pcm;
                    pcm_valid  <= 1'b1;
                end else begin
                    r_ones_acc <= w_ones;
                end
            end
        end
    end
endmodule

// File: rtl/pdm_sample.sv
// PDM microphone front end: decimates to 16-bit PCM and packs sample pairs
// into 32-bit words with a single-cycle write strobe for the sample RAM.
module pdm_sample
    import pdm_pkg::*;
#(
    parameter int DECIM = DECIM_DEF
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      count_en,
    input  logic      micData,
    output ram_word_t ram_data,
    output logic      ram_wr
);
    pcm_t      w_pcm_q;
    logic      w_pcm_valid;
    logic      w_close;
    pcm_t      w_pcm_now;

    logic      r_half;
    pcm_t      r_low_hold;
    ram_word_t r_ram_data;
    logic      r_ram_wr;

    pdm_decim #(.DECIM(DECIM)) u_decim (
        .clk       (clk),
        .rst       (rst),
        .count_en  (count_en),
        .micData   (micData),
        .pcm       (w_pcm_q),
        .pcm_valid (w_pcm_valid),
        .close_now (w_close),
        .pcm_now   (w_pcm_now)
    );

    // The older sample is latched from the registered decimator output; it
    // lands long before the next window closes. The newer sample is taken
    // combinationally so the write strobe follows the closing edge directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_half     <= 1'b0;
            r_low_hold <= '0;
            r_ram_data <= '0;
            r_ram_wr   <= 1'b0;
        end else begin
            r_ram_wr <= 1'b0;
            if (w_pcm_valid && r_half) begin
                r_low_hold <= w_pcm_q;
            end
            if (w_close) begin
                if (r_half) begin
                    r_ram_data <= {w_pcm_now, r_low_hold};
                    r_ram_wr   <= 1'b1;
                    r_half     <= 1'b0;
                end else begin
                    r_half <= 1'b1;
                end
            end
        end
    end

    assign ram_data = r_ram_data;
    assign ram_wr   = r_ram_wr;
endmodule

// File: tb/tb_pdm_sample.sv
// Self-checking bench for pdm_sample (DECIM = 64) against a window/pair model.
module tb_pdm_sample;
    localparam int DECIM = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        count_en;
    logic        micData;
    logic [31:0] ram_data;
    logic        ram_wr;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model: bits of the open window and samples awaiting a pair
    logic        win[$];
    logic [15:0] samples[$];
    logic [31:0] m_data;
    logic        m_wr;

    int          cyc, n_wr, first_wr, last_wr, min_gap, max_gap;
    logic [31:0] last_word;

    pdm_sample #(.DECIM(DECIM)) dut (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .micData  (micData),
        .ram_data (ram_data),
        .ram_wr   (ram_wr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        win.delete();
        samples.delete();
        m_data = '0;
        m_wr   = 1'b0;
    endtask

    task automatic start_scen();
        cyc       = 0;
        n_wr      = 0;
        first_wr  = -1;
        last_wr   = 0;
        min_gap   = 1000000;
        max_gap   = 0;
        last_word = '0;
    endtask

    // entered and left at posedge+1
    task automatic step(input logic en, input logic b);
        int ones;
        count_en = en;
        micData  = b;
        @(posedge clk);
        m_wr = 1'b0;
        if (en) begin
            win.push_back(b);
            if (win.size() == DECIM) begin
                ones = 0;
                foreach (win[i]) ones += int'(win[i]);
                win.delete();
                samples.push_back(16'(ones - DECIM / 2));
                if (samples.size() == 2) begin
                    m_data = {samples[1], samples[0]};
                    m_wr   = 1'b1;
                    samples.delete();
                end
            end
        end
        #1;
        cyc++;
        chk("ram_wr", 32'(ram_wr), 32'(m_wr));
        chk("ram_data", ram_data, m_data);
        if (ram_wr) begin
            n_wr++;
            if (first_wr < 0) first_wr = cyc;
            else begin
                if (cyc - last_wr < min_gap) min_gap = cyc - last_wr;
                if (cyc - last_wr > max_gap) max_gap = cyc - last_wr;
            end
            last_wr   = cyc;
            last_word = ram_data;
        end
    endtask

    // asynchronous reset asserted away from the clock edge
    task automatic do_reset();
        rst      = 1'b0;
        count_en = 1'b0;
        #2;
        chk("rst_async_wr", 32'(ram_wr), 32'h0);
        chk("rst_async_data", ram_data, 32'h0);
        model_clear();
        @(posedge clk);
        #1;
        chk("rst_hold_wr", 32'(ram_wr), 32'h0);
        chk("rst_hold_data", ram_data, 32'h0);
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        count_en = 1'b0;
        micData  = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
        chk("por_wr", 32'(ram_wr), 32'h0);
        chk("por_data", ram_data, 32'h0);
        rst = 1'b1;

        // constant ones
        start_scen();
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b1);
        chk("ones_nwr", 32'(n_wr), 32'd15);
        chk("ones_first", 32'(first_wr), 32'd128);
        chk("ones_gap_min", 32'(min_gap), 32'd128);
        chk("ones_gap_max", 32'(max_gap), 32'd128);
        chk("ones_word", last_word, 32'h0020_0020);

        // constant zeros
        do_reset();
        start_scen();
        for (int i = 0; i < 1000; i++) step(1'b1, 1'b0);
        chk("zeros_nwr", 32'(n_wr), 32'd7);
        chk("zeros_word", last_word, 32'hFFE0_FFE0);

        // alternating bits
        do_reset();
        start_scen();
        for (int i = 0; i < 1000; i++) step(1'b1, (i % 2) == 0);
        chk("alt_nwr", 32'(n_wr), 32'd7);
        chk("alt_word", last_word, 32'h0000_0000);

        // sparse enable, every 4th cycle
        do_reset();
        start_scen();
        for (int i = 0; i < 2100; i++) step((i % 4) == 0, 1'b1);
        chk("sparse_nwr", 32'(n_wr), 32'd4);
        chk("sparse_first", 32'(first_wr), 32'd509);
        chk("sparse_gap_min", 32'(min_gap), 32'd512);
        chk("sparse_gap_max", 32'(max_gap), 32'd512);
        chk("sparse_word", last_word, 32'h0020_0020);

        // mixed pair: older sample in the low half
        do_reset();
        start_scen();
        for (int i = 0; i < DECIM; i++) step(1'b1, 1'b1);
        for (int i = 0; i < DECIM; i++) step(1'b1, 1'b0);
        chk("mixed_nwr", 32'(n_wr), 32'd1);
        chk("mixed_word", last_word, 32'hFFE0_0020);

        // reset mid-pair discards the pending window and sample
        do_reset();
        start_scen();
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1);
        do_reset();
        start_scen();
        for (int i = 0; i < 2 * DECIM - 1; i++) step(1'b1, 1'b0);
        chk("rstmid_early", 32'(n_wr), 32'd0);
        step(1'b1, 1'b0);
        chk("rstmid_nwr", 32'(n_wr), 32'd1);
        chk("rstmid_first", 32'(first_wr), 32'd128);
        chk("rstmid_word", last_word, 32'hFFE0_FFE0);

        // random density, random enable gaps, one reset mid-run
        do_reset();
        start_scen();
        for (int seg = 0; seg < 30; seg++) begin
            int p;
            p = int'($urandom_range(0, 100));
            if (seg == 15) do_reset();
            for (int i = 0; i < 150; i++)
                step($urandom_range(0, 9) < 7, int'($urandom_range(0, 99)) < p);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
